seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Reads a multiplexed, active-low 7-segment display bus (seg/an) and recovers the
//  four displayed digits as BCD.
//  It is the receiving end of the counter/bcd-to-7seg display path. Used as an
//  on-board loopback monitor and as a self-check target for the display driver.
//  Filters anode-scan glitches, flags invalid patterns, and ages out stale digits.
// PARAMETERS
//  STABLE_CYCLES   16         consecutive identical synced samples required to accept a slot
//  TIMEOUT_CYCLES  2_000_000  cycles without a refresh before a digit is marked stale (20 ms @100 MHz)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  seg          in   7   segment lines, active-low, seg[6:0] = {g,f,e,d,c,b,a}
//  an           in   4   anode enables, active-low, an[i] selects digit i
//  digits       out  16  recovered BCD, digits[4i+3:4i] = digit i
//  digit_valid  out  4   digit i holds a fresh, decodable value
//  pattern_err  out  4   sticky: digit i was last seen with an undecodable pattern
//  update       out  1   one-cycle pulse when any digits/digit_valid bit changes
// BEHAVIOUR
//  - Reset (async assert, sync release): digits=0, digit_valid=0, pattern_err=0, update=0,
//    synchronizers and counters cleared. Reset mid-capture discards all partial state.
//  - seg and an pass through a 2-FF synchronizer. The synced pair {an,seg} is compared with the
//    previous cycle's pair. Equal -> stab_cnt++ (saturating at STABLE_CYCLES); differs -> stab_cnt=0.
//  - A slot is accepted when stab_cnt==STABLE_CYCLES and exactly one an bit is low.
//    an==4'b1111 or >1 low -> ignored, no state change.
//  - Latency: a pin change is reflected on the outputs at the edge 2+STABLE_CYCLES+1
//    after the change. That is 2 sync stages, STABLE_CYCLES matching samples, and 1 register.
//  - On accept for digit i, seg is decoded as follows:
//      0:1000000 1:1111001 2:0100100 3:0110000 4:0011001
//      5:0010010 6:0000010 7:1111000 8:0000000 9:0010000
//      decoded    -> digits[i]=value, digit_valid[i]=1, pattern_err[i]=0
//      7'b1111111 -> blank: digit_valid[i]=0, digits[i] unchanged, pattern_err[i]=0
//      other      -> pattern_err[i]=1, digit_valid[i]=0, digits[i] unchanged
//  - While a slot stays accepted, the accept fires every cycle (idempotent write).
//    It also reloads that digit's stale timer.
//  - Stale timer: one down-counter per digit, reloaded to TIMEOUT_CYCLES-1 on accept.
//    On reaching 0: digit_valid[i]=0 (digits and pattern_err kept). The timer then holds at 0.
//  - Accept and timeout expiry for the same digit in the same cycle -> accept wins.
//  - update pulses 1 cycle after a cycle in which any digits/digit_valid bit changed.
//    An idempotent accept produces no pulse.
//  - Timer width = $clog2(TIMEOUT_CYCLES); stab_cnt width = $clog2(STABLE_CYCLES+1).
// CONFIGURATION
//  SEG7_HEX_DECODE_EN defined: additionally decodes the following, with digit_valid=1:
//      A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110  (values 10..15)
//  Undefined: those patterns are undecodable and set pattern_err.
// STRUCTURE
//  - Package seg7_pkg holds:
//      the pattern constants SEG7_DIG_0..SEG7_DIG_F
//      SEG7_BLANK = 7'b1111111
//      typedef seg7_pat_t (logic [6:0]) and bcd_t (logic [3:0])
//  - Sub-module seg7_to_bcd: combinational lookup seg7_pat_t -> {ok, blank, bcd_t}.
//    The hex extension is guarded by the macro inside it.
//  - Top: synchronizer, stability counter, slot select, 4 digit registers, 4 stale timers.
// TESTING
//  (STABLE_CYCLES=4, TIMEOUT_CYCLES=64 in the bench)
//  1. Scan an=1110 seg=0100100 for 10 cycles.
//     -> after 7 edges: digits[3:0]=2, digit_valid=0001, update pulses once.
//  2. Round-robin 3,0,4,9 on digits 0..3, 20 cycles per slot.
//     -> digits=16'h9403, digit_valid=1111, no further update pulses on a repeat scan.
//  3. Digit 1 driven with 0001000, macro undefined: pattern_err=0010, digit_valid[1]=0.
//     Same pattern with macro defined: digits[7:4]=4'hA, digit_valid[1]=1.
//  4. 2-cycle glitch an=1100 and seg toggling every 3 cycles -> no output change.
//  5. After test 2, stop scanning digit 2 -> 64 cycles later digit_valid=1011,
//     digits unchanged, one update pulse.
//  6. Assert rst_n=0 mid-scan for 1 cycle -> all outputs 0 immediately.
//     Recovery follows test 1 timing.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants and types for the scan decoder.
package seg7_pkg;

   typedef logic [6:0] seg7_pat_t;
   typedef logic [3:0] bcd_t;

   // Active-low patterns, bit order {g,f,e,d,c,b,a}
   localparam seg7_pat_t SEG7_DIG_0 = 7'b1000000;
   localparam seg7_pat_t SEG7_DIG_1 = 7'b1111001;
   localparam seg7_pat_t SEG7_DIG_2 = 7'b0100100;
   localparam seg7_pat_t SEG7_DIG_3 = 7'b0110000;
   localparam seg7_pat_t SEG7_DIG_4 = 7'b0011001;
   localparam seg7_pat_t SEG7_DIG_5 = 7'b0010010;
   localparam seg7_pat_t SEG7_DIG_6 = 7'b0000010;
   localparam seg7_pat_t SEG7_DIG_7 = 7'b1111000;
   localparam seg7_pat_t SEG7_DIG_8 = 7'b0000000;
   localparam seg7_pat_t SEG7_DIG_9 = 7'b0010000;
   localparam seg7_pat_t SEG7_DIG_A = 7'b0001000;
   localparam seg7_pat_t SEG7_DIG_B = 7'b0000011;
   localparam seg7_pat_t SEG7_DIG_C = 7'b1000110;
   localparam seg7_pat_t SEG7_DIG_D = 7'b0100001;
   localparam seg7_pat_t SEG7_DIG_E = 7'b0000110;
   localparam seg7_pat_t SEG7_DIG_F = 7'b0001110;
   localparam seg7_pat_t SEG7_BLANK = 7'b1111111;

   // True when exactly one active-low anode is asserted
   function automatic logic seg7_one_anode(input logic [3:0] an);
      return $onehot(~an);
   endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// rtl/seg7_scan_decoder_if.sv - display bus (seg/an) plus recovered-digit outputs of the scan decoder.
interface seg7_scan_decoder_if;
   import seg7_pkg::*;

   seg7_pat_t   seg;
   logic [3:0]  an;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic [3:0]  pattern_err;
   logic        update;

   modport master (
      output seg, an,
      input  digits, digit_valid, pattern_err, update
   );

   modport slave (
      input  seg, an,
      output digits, digit_valid, pattern_err, update
   );

endinterface

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational 7-segment pattern lookup; hex A..F decoded when SEG7_HEX_DECODE_EN is defined.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  seg7_pat_t pat_i,
   output logic      ok_o,
   output logic      blank_o,
   output bcd_t      bcd_o
);

   always_comb begin
      ok_o    = 1'b1;
      blank_o = 1'b0;
      bcd_o   = 4'd0;
      case (pat_i)
         SEG7_DIG_0: bcd_o = 4'd0;
         SEG7_DIG_1: bcd_o = 4'd1;
         SEG7_DIG_2: bcd_o = 4'd2;
         SEG7_DIG_3: bcd_o = 4'd3;
         SEG7_DIG_4: bcd_o = 4'd4;
         SEG7_DIG_5: bcd_o = 4'd5;
         SEG7_DIG_6: bcd_o = 4'd6;
         SEG7_DIG_7: bcd_o = 4'd7;
         SEG7_DIG_8: bcd_o = 4'd8;
         SEG7_DIG_9: bcd_o = 4'd9;
`ifdef SEG7_HEX_DECODE_EN
         SEG7_DIG_A: bcd_o = 4'd10;
         SEG7_DIG_B: bcd_o = 4'd11;
         SEG7_DIG_C: bcd_o = 4'd12;
         SEG7_DIG_D: bcd_o = 4'd13;
         SEG7_DIG_E: bcd_o = 4'd14;
         SEG7_DIG_F: bcd_o = 4'd15;
`endif
         SEG7_BLANK: begin
            ok_o    = 1'b0;
            blank_o = 1'b1;
         end
         default:    ok_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers four BCD digits from a multiplexed active-low seg/an bus.
// Hex digits A..F are accepted when SEG7_HEX_DECODE_EN is defined (see seg7_to_bcd).
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 2_000_000
)
(
   input  logic              clk,
   input  logic              rst_n,
   seg7_scan_decoder_if.slave bus
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] STAB_MAX     = CW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(TIMEOUT_CYCLES - 1);

   logic [10:0]   sync1_q, sync2_q, prev_q;
   logic [CW-1:0] stab_cnt_q, stab_cnt_d;
   logic [15:0]   digits_q, digits_d;
   logic [3:0]    valid_q, valid_d;
   logic [3:0]    err_q, err_d;
   logic          update_q, update_d;
   logic [TW-1:0] timer_q [4];
   logic [TW-1:0] timer_d [4];

   logic [3:0]    an_s;
   seg7_pat_t     seg_s;
   logic          dec_ok, dec_blank, accept;
   bcd_t          dec_bcd;

   assign an_s  = sync2_q[10:7];
   assign seg_s = sync2_q[6:0];

   seg7_to_bcd u_dec (
      .pat_i   (seg_s),
      .ok_o    (dec_ok),
      .blank_o (dec_blank),
      .bcd_o   (dec_bcd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         stab_cnt_q <= '0;
         digits_q   <= '0;
         valid_q    <= '0;
         err_q      <= '0;
         update_q   <= 1'b0;
         for (int i = 0; i < 4; i++) timer_q[i] <= '0;
      end else begin
         sync1_q    <= {bus.an, bus.seg};
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         stab_cnt_q <= stab_cnt_d;
         digits_q   <= digits_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         update_q   <= update_d;
         for (int i = 0; i < 4; i++) timer_q[i] <= timer_d[i];
      end
   end

   always_comb begin
      if (sync2_q != prev_q)        stab_cnt_d = '0;
      else if (stab_cnt_q == STAB_MAX) stab_cnt_d = stab_cnt_q;
      else                          stab_cnt_d = stab_cnt_q + CW'(1);

      // Acceptance looks at the next count so the digit register is the only stage after the match window
      accept = (stab_cnt_d == STAB_MAX) && seg7_one_anode(an_s);

      digits_d = digits_q;
      valid_d  = valid_q;
      err_d    = err_q;
      for (int i = 0; i < 4; i++) begin
         timer_d[i] = timer_q[i];
         if (accept && !an_s[i]) begin
            timer_d[i] = TIMER_RELOAD;
            if (dec_ok) begin
               digits_d[4*i +: 4] = dec_bcd;
               valid_d[i]         = 1'b1;
               err_d[i]           = 1'b0;
            end else begin
               valid_d[i] = 1'b0;
               err_d[i]   = !dec_blank;
            end
         end else if (timer_q[i] == '0) begin
            valid_d[i] = 1'b0;
         end else begin
            timer_d[i] = timer_q[i] - TW'(1);
         end
      end

      update_d = (digits_d != digits_q) || (valid_d != valid_q);
   end

   assign bus.digits      = digits_q;
   assign bus.digit_valid = valid_q;
   assign bus.pattern_err = err_q;
   assign bus.update      = update_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder: directed tables plus random scans vs a reference model.
module tb_seg7_scan_decoder;

   localparam int S = 4;
   localparam int T = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg7_scan_decoder_if bus ();

   seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total   = 0;
   int bad     = 0;
   int upd_cnt = 0;
   int ndec;

   logic [6:0]  pat [16];
   logic [10:0] hist [$];
   logic [3:0]  mdig [4];
   logic [3:0]  mval, merr;
   logic        mupd;
   int          mlast [4];

   typedef struct {
      int         dig;
      logic [6:0] seg;
      logic [3:0] nib;
      logic       val;
      logic       err;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mdigits();
      return {mdig[3], mdig[2], mdig[1], mdig[0]};
   endfunction

   task automatic m_reset();
      hist.delete();
      for (int k = 0; k < S + 3; k++) hist.push_back(11'h0);
      for (int i = 0; i < 4; i++) begin
         mdig[i]  = 4'h0;
         mlast[i] = -100000;
      end
      mval = 4'h0;
      merr = 4'h0;
      mupd = 1'b0;
   endtask

   // A slot is seen at edge m when the inputs applied before edges m-2-S .. m-2 were all identical
   task automatic m_step();
      int          m;
      int          found;
      logic        run;
      logic [10:0] v;
      logic [15:0] old_d;
      logic [3:0]  old_v;
      m     = hist.size() - 1;
      old_d = mdigits();
      old_v = mval;
      run   = 1'b1;
      for (int k = 0; k < S; k++)
         if (hist[m-2-k] !== hist[m-3-k]) run = 1'b0;
      v = hist[m-2];
      for (int i = 0; i < 4; i++) begin
         if (run && $countones(~v[10:7]) == 1 && v[7+i] == 1'b0) begin
            found = -1;
            for (int j = 0; j < ndec; j++)
               if (pat[j] == v[6:0]) found = j;
            if (found >= 0) begin
               mdig[i] = found[3:0];
               mval[i] = 1'b1;
               merr[i] = 1'b0;
            end else if (v[6:0] == 7'h7f) begin
               mval[i] = 1'b0;
               merr[i] = 1'b0;
            end else begin
               mval[i] = 1'b0;
               merr[i] = 1'b1;
            end
            mlast[i] = m;
         end else if (m - mlast[i] >= T) begin
            mval[i] = 1'b0;
         end
      end
      mupd = (mdigits() != old_d) || (mval != old_v);
   endtask

   task automatic tick(input logic [3:0] a, input logic [6:0] s);
      bus.an  = a;
      bus.seg = s;
      hist.push_back({a, s});
      @(posedge clk);
      m_step();
      #1;
      chk("model_digits", 32'(bus.digits), 32'(mdigits()));
      chk("model_valid", 32'(bus.digit_valid), 32'(mval));
      chk("model_err", 32'(bus.pattern_err), 32'(merr));
      chk("model_update", 32'(bus.update), 32'(mupd));
      if (bus.update) upd_cnt++;
   endtask

   task automatic slot(input int d, input logic [6:0] s, input int n);
      logic [3:0] a;
      a    = 4'hF;
      a[d] = 1'b0;
      repeat (n) tick(a, s);
   endtask

   task automatic scan_round(input int n);
      slot(0, pat[3], n);
      slot(1, pat[0], n);
      slot(2, pat[4], n);
      slot(3, pat[9], n);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_digits"}, 32'(bus.digits), 32'h0);
      chk({tag, "_valid"}, 32'(bus.digit_valid), 32'h0);
      chk({tag, "_err"}, 32'(bus.pattern_err), 32'h0);
      chk({tag, "_update"}, 32'(bus.update), 32'h0);
   endtask

   task automatic first_digit_seq(input string tag);
      upd_cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         slot(0, pat[2], 1);
         chk({tag, "_valid"}, 32'(bus.digit_valid), (k >= 7) ? 32'h1 : 32'h0);
         chk({tag, "_dig0"}, 32'(bus.digits[3:0]), (k >= 7) ? 32'h2 : 32'h0);
      end
      chk({tag, "_pulses"}, 32'(upd_cnt), 32'h1);
   endtask

   initial begin
      logic [3:0] ra;
      logic [6:0] rs;
      int         r;

      pat[0]  = 7'b1000000; pat[1]  = 7'b1111001; pat[2]  = 7'b0100100; pat[3]  = 7'b0110000;
      pat[4]  = 7'b0011001; pat[5]  = 7'b0010010; pat[6]  = 7'b0000010; pat[7]  = 7'b1111000;
      pat[8]  = 7'b0000000; pat[9]  = 7'b0010000; pat[10] = 7'b0001000; pat[11] = 7'b0000011;
      pat[12] = 7'b1000110; pat[13] = 7'b0100001; pat[14] = 7'b0000110; pat[15] = 7'b0001110;
`ifdef SEG7_HEX_DECODE_EN
      ndec = 16;
`else
      ndec = 10;
`endif

      tbl[0] = '{0, 7'b1111000, 4'h7, 1'b1, 1'b0};
      tbl[1] = '{1, 7'b0000010, 4'h6, 1'b1, 1'b0};
      tbl[2] = '{2, 7'b1111001, 4'h1, 1'b1, 1'b0};
      tbl[3] = '{3, 7'b1000000, 4'h0, 1'b1, 1'b0};
      tbl[4] = '{0, 7'b1111111, 4'h7, 1'b0, 1'b0};
      tbl[5] = '{1, 7'b0000001, 4'h6, 1'b0, 1'b1};
`ifdef SEG7_HEX_DECODE_EN
      tbl[6] = '{2, 7'b1000110, 4'hC, 1'b1, 1'b0};
      tbl[7] = '{3, 7'b0001110, 4'hF, 1'b1, 1'b0};
`else
      tbl[6] = '{2, 7'b1000110, 4'h1, 1'b0, 1'b1};
      tbl[7] = '{3, 7'b0001110, 4'h0, 1'b0, 1'b1};
`endif
      tbl[8] = '{1, 7'b0010000, 4'h9, 1'b1, 1'b0};
      tbl[9] = '{0, 7'b0100100, 4'h2, 1'b1, 1'b0};

      bus.an  = 4'hF;
      bus.seg = 7'h7f;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      m_reset();

      first_digit_seq("t1");

      for (int i = 0; i < 10; i++) begin
         slot(tbl[i].dig, tbl[i].seg, 12);
         chk($sformatf("tbl%0d_nib", i), 32'(bus.digits[4*tbl[i].dig +: 4]), 32'(tbl[i].nib));
         chk($sformatf("tbl%0d_valid", i), 32'(bus.digit_valid[tbl[i].dig]), 32'(tbl[i].val));
         chk($sformatf("tbl%0d_err", i), 32'(bus.pattern_err[tbl[i].dig]), 32'(tbl[i].err));
      end

      scan_round(12);
      chk("t2_digits", 32'(bus.digits), 32'h9403);
      chk("t2_valid", 32'(bus.digit_valid), 32'hF);
      chk("t2_err", 32'(bus.pattern_err), 32'h0);
      upd_cnt = 0;
      scan_round(12);
      chk("t2_repeat_pulses", 32'(upd_cnt), 32'h0);

      upd_cnt = 0;
      repeat (2) tick(4'b1100, pat[3]);
      for (int k = 0; k < 3; k++) repeat (3) tick(4'b1110, (k == 1) ? pat[8] : pat[3]);
      scan_round(12);
      chk("t4_pulses", 32'(upd_cnt), 32'h0);
      chk("t4_digits", 32'(bus.digits), 32'h9403);
      chk("t4_valid", 32'(bus.digit_valid), 32'hF);

      slot(1, 7'b0001000, 12);
`ifdef SEG7_HEX_DECODE_EN
      chk("t3_dig1", 32'(bus.digits[7:4]), 32'hA);
      chk("t3_valid1", 32'(bus.digit_valid[1]), 32'h1);
      chk("t3_err", 32'(bus.pattern_err), 32'h0);
`else
      chk("t3_err", 32'(bus.pattern_err), 32'h2);
      chk("t3_valid1", 32'(bus.digit_valid[1]), 32'h0);
      chk("t3_dig1", 32'(bus.digits[7:4]), 32'h0);
`endif

      scan_round(12);
      chk("t5_restore", 32'(bus.digits), 32'h9403);
      upd_cnt = 0;
      repeat (5) begin
         slot(0, pat[3], 12);
         slot(1, pat[0], 12);
         slot(3, pat[9], 12);
      end
      chk("t5_valid", 32'(bus.digit_valid), 32'hB);
      chk("t5_digits", 32'(bus.digits), 32'h9403);
      chk("t5_pulses", 32'(upd_cnt), 32'h1);

      slot(0, pat[3], 5);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("t6_async");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_reset();
      first_digit_seq("t6");

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            ra = 4'hF;
            ra[$urandom_range(0, 3)] = 1'b0;
         end else begin
            ra = 4'($urandom);
         end
         r = $urandom_range(0, 9);
         if (r < 6)       rs = pat[$urandom_range(0, 15)];
         else if (r == 6) rs = 7'h7f;
         else             rs = 7'($urandom);
         repeat ($urandom_range(1, 14)) tick(ra, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
